sr_nv_ctf_chain: RTL and testbench
==================================

Name: sr_nv_ctf_chain

Overview:
- Parametrised, synchronous successor to the single counterflow shift register cell: a STAGES-deep, WIDTH-bit chain of destructive-readout (DRO) stages.
- Data flows forward from stage 0 to stage STAGES-1. Clock pulses enter at the last stage and ripple backward with a programmable per-stage delay.
- Setup and hold windows are checked per stage in cycles. Violations are reported by flag and stage index instead of X-propagation.
- Used as the cycle-accurate model of counterflow-clocked shift paths in the synchronous simulation flow.

Parameters:
- WIDTH, 4: bits per stage.
- STAGES, 4: number of DRO stages, ≥2.
- CLK_DLY, 2: cycles a clock pulse takes from stage i to stage i-1, ≥1.
- T_SETUP, 2: minimum cycles from data arrival at a stage to that stage's next clock.
- T_HOLD, 2: minimum cycles from a stage's clock to the next data arrival there. Must satisfy T_HOLD ≤ CLK_DLY+1.
- CNT_W, 8: width of the violation counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- din_vld  in  1  data pulse into stage 0.
- din  in  WIDTH  data value.
- cin  in  1  clock pulse into stage STAGES-1.
- dout_vld  out  1  stage STAGES-1 was read.
- dout  out  WIDTH  value read from stage STAGES-1.
- cout  out  1  clock pulse leaving stage 0.
- viol  out  1  timing violation occurred.
- viol_stage  out  $clog2(STAGES)  stage index of the violation.
- viol_cnt  out  CNT_W  saturating violation count.

Behaviour:
- Reset (rst sampled high at an edge):
  - clears all stage states s[i], the clock-delay pipeline, all age counters and viol_cnt.
  - drives all outputs to 0.
  - ignores cin/din_vld sampled in the reset cycle.
  - drops clock pulses already in flight; no cout or dout_vld results from them.
- Clock events c[i]:
  - c[STAGES-1] = cin.
  - c[i-1] = c[i] delayed exactly CLK_DLY cycles.
  - Several pulses may be in flight at once.
- Data arrival a[i]:
  - a[0] = din_vld with din≠0.
  - a[i+1] at t+1 = nonzero transfer from stage i clocked at t.
  - A zero value is not a pulse and is never an arrival.
- Arrival at a stage ORs the value into s[i] (DRO set).
- Clock at a stage at t:
  - transfers s[i] to stage i+1, or to dout for the last stage.
  - clears s[i].
- dout_vld and dout register at t+1 after c[STAGES-1], on every clock, including a zero value.
- cout is high at t+1 after c[0].
- Age counters per stage:
  - clk_age[i] = cycles since c[i]; dat_age[i] = cycles since a[i].
  - Both saturate at max(T_SETUP,T_HOLD).
  - Both are saturated after reset, i.e. no violation is possible immediately after reset.
- Setup violation: c[i] at t with the last arrival at t'' and t-t'' < T_SETUP.
  - Transferred value forced to 0; s[i] cleared.
- Hold violation: a[i] at t with the last clock at t' and 0 < t-t' < T_HOLD.
  - Arriving value dropped; s[i] unchanged.
- Simultaneous c[i] and a[i] in the same cycle:
  - one setup violation only.
  - the old state is transferred as 0.
  - the new data is discarded.
- Violation reporting:
  - viol pulses at t+1 for any violation in cycle t.
  - viol_stage = lowest violating stage in that cycle.
  - viol_cnt += 1 per violating cycle, saturating at all-ones.
- Latency: stage 0 to dout takes STAGES cin pulses. Each pulse reaches stage 0 (STAGES-1)*CLK_DLY cycles after cin.

Optional Feature:
- Macro: SR_NV_CTF_VIOL_CNT_EN.
- Defined: viol_stage and viol_cnt are live as above.
- Undefined:
  - viol_stage and viol_cnt are tied to 0 and no counter logic is built.
  - viol is still generated.

Test Plan:
- Shift-through:
  - Stimulus: reset, then din_vld@0 with din=4'hA; cin@10,30,50,70.
  - Clock path: c0 events at 16,36,56,76; cout@17,37,57,77.
  - Data path: dout_vld@11,31,51,71 with dout=0,0,0,4'hA; no viol.
- Setup violation:
  - Stimulus: cin@18 (c0@24); din_vld@23 with din=5.
  - Response: viol@25, viol_stage=0, viol_cnt=1; no arrival at stage 1; s0 cleared.
- Hold violation:
  - Stimulus: cin@10 (c0@16); din_vld@17 with din=3.
  - Response: viol@18, viol_stage=0; data dropped.
  - Follow-up: din_vld@18 with din=3 is accepted and emerges at stage 1 on the next cin.
- Simultaneous events:
  - Stimulus: cin@10; din_vld@16 with din=F.
  - Response: exactly one viol pulse @17; viol_cnt increments by 1; nothing transferred.
- Back-to-back clocks and saturation:
  - cin@10 and cin@11: two dout_vld pulses @11,@12 and two cout pulses @17,@18. The second read returns 0.
  - CNT_W=2 with 5 violations: viol_cnt holds 3.
- Reset mid-operation:
  - Stimulus: stage 0 loaded with 4'hA; cin@10; rst high @13.
  - Response: no cout; no further dout_vld after @11; all states 0.
  - Follow-up: cin@20 yields dout_vld@21 with dout=0.

Source files
------------

// File: rtl/sr_nv_ctf_chain.sv
// sr_nv_ctf_chain: STAGES-deep, WIDTH-bit chain of destructive-readout stages.
// Data moves forward from stage 0 to stage STAGES-1. Clock pulses enter at the
// last stage and travel backward, taking CLK_DLY cycles per stage. Setup and
// hold windows are checked per stage in cycles. A violation is reported on
// viol and squashes the offending data; it never produces X values.
// Optional feature macro: SR_NV_CTF_VIOL_CNT_EN builds the violating-stage
// index and the saturating violation counter. Without it, both are tied to 0.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   din_vld, din      data pulse and value into stage 0 (a zero value is no pulse)
//   cin               clock pulse into stage STAGES-1
//   dout_vld, dout    stage STAGES-1 was read, and the value read
//   cout              clock pulse leaving stage 0
//   viol              a timing violation occurred in the previous cycle
//   viol_stage        lowest violating stage of that cycle
//   viol_cnt          saturating count of violating cycles
module sr_nv_ctf_chain #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned STAGES  = 4,
  parameter int unsigned CLK_DLY = 2,
  parameter int unsigned T_SETUP = 2,
  parameter int unsigned T_HOLD  = 2,
  parameter int unsigned CNT_W   = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      din_vld,
  input  logic [WIDTH-1:0]          din,
  input  logic                      cin,
  output logic                      dout_vld,
  output logic [WIDTH-1:0]          dout,
  output logic                      cout,
  output logic                      viol,
  output logic [$clog2(STAGES)-1:0] viol_stage,
  output logic [CNT_W-1:0]          viol_cnt
);

  localparam int unsigned SW      = $clog2(STAGES);
  localparam int unsigned AGE_MAX = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned AGE_W   = $clog2(AGE_MAX + 2);

  logic [STAGES-1:0]  c, a, su, ho, acc;
  logic [WIDTH-1:0]   av   [STAGES];
  logic [WIDTH-1:0]   xn   [STAGES];
  logic [WIDTH-1:0]   s_q  [STAGES];
  logic [WIDTH-1:0]   xv_q [STAGES-1];
  logic [CLK_DLY-1:0] pipe_q [STAGES-1];
  logic [AGE_W-1:0]   clk_age_q [STAGES];
  logic [AGE_W-1:0]   dat_age_q [STAGES];
  logic               vio;

  // Increment an age counter, stopping at AGE_MAX.
  function automatic logic [AGE_W-1:0] sat_inc(input logic [AGE_W-1:0] v);
    return (v < AGE_W'(AGE_MAX)) ? v + AGE_W'(1) : v;
  endfunction

  // Per-stage clock and arrival events, timing checks and transfer values.
  always_comb begin
    c   = '0;
    a   = '0;
    su  = '0;
    ho  = '0;
    acc = '0;
    vio = 1'b0;
    for (int i = 0; i < STAGES; i++) begin
      av[i] = '0;
      xn[i] = '0;
    end
    c[STAGES-1] = cin;
    for (int j = 0; j < STAGES-1; j++) c[j] = pipe_q[j][CLK_DLY-1];
    a[0]  = din_vld && (din != '0);
    av[0] = din;
    for (int j = 1; j < STAGES; j++) begin
      av[j] = xv_q[j-1];
      a[j]  = (xv_q[j-1] != '0);
    end
    for (int i = 0; i < STAGES; i++) begin
      // A same-cycle arrival counts as zero setup time.
      su[i]  = c[i] && (a[i] || (dat_age_q[i] < AGE_W'(T_SETUP)));
      ho[i]  = a[i] && !c[i] && (clk_age_q[i] < AGE_W'(T_HOLD));
      acc[i] = a[i] && !su[i] && !ho[i];
      xn[i]  = (c[i] && !su[i]) ? s_q[i] : WIDTH'(0);
    end
    vio = |(su | ho);
  end

  // Stage state, clock-delay pipeline, age counters and main outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i]       <= '0;
        clk_age_q[i] <= AGE_W'(AGE_MAX);
        dat_age_q[i] <= AGE_W'(AGE_MAX);
      end
      for (int j = 0; j < STAGES-1; j++) begin
        pipe_q[j] <= '0;
        xv_q[j]   <= '0;
      end
      dout_vld <= 1'b0;
      dout     <= '0;
      cout     <= 1'b0;
      viol     <= 1'b0;
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        s_q[i]       <= (c[i] ? WIDTH'(0) : s_q[i]) | (acc[i] ? av[i] : WIDTH'(0));
        clk_age_q[i] <= c[i] ? AGE_W'(1) : sat_inc(clk_age_q[i]);
        dat_age_q[i] <= a[i] ? AGE_W'(1) : sat_inc(dat_age_q[i]);
      end
      for (int j = 0; j < STAGES-1; j++) begin
        pipe_q[j] <= (pipe_q[j] << 1) | CLK_DLY'(c[j+1]);
        xv_q[j]   <= xn[j];
      end
      dout_vld <= c[STAGES-1];
      if (c[STAGES-1]) dout <= xn[STAGES-1];
      cout <= c[0];
      viol <= vio;
    end
  end

`ifdef SR_NV_CTF_VIOL_CNT_EN
  logic [SW-1:0] low;

  // Lowest violating stage of the current cycle.
  always_comb begin
    low = '0;
    for (int i = STAGES-1; i >= 0; i--) begin
      if (su[i] || ho[i]) low = SW'(i);
    end
  end

  // Violation index and saturating counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      viol_stage <= '0;
      viol_cnt   <= '0;
    end else begin
      viol_stage <= low;
      if (vio && (viol_cnt != '1)) viol_cnt <= viol_cnt + CNT_W'(1);
    end
  end
`else
  assign viol_stage = '0;
  assign viol_cnt   = '0;
`endif

endmodule

// File: tb/tb_sr_nv_ctf_chain.sv
// Directed bench for sr_nv_ctf_chain with default parameters (CLK_DLY=2).
// A second instance with CNT_W=2 shares the stimulus to show counter saturation.
// Cycle t: inputs are driven before posedge t; outputs seen in cycle t were
// registered at posedge t-1 and are sampled on the falling edge.
module tb_sr_nv_ctf_chain;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned STAGES = 4;
  localparam int unsigned SW     = $clog2(STAGES);

  logic             clk = 1'b0;
  logic             rst, din_vld, cin;
  logic [WIDTH-1:0] din;
  logic             dout_vld, cout, viol;
  logic [WIDTH-1:0] dout;
  logic [SW-1:0]    viol_stage;
  logic [7:0]       viol_cnt;
  logic             dout_vld_b, cout_b, viol_b;
  logic [WIDTH-1:0] dout_b;
  logic [SW-1:0]    viol_stage_b;
  logic [1:0]       viol_cnt_b;

  sr_nv_ctf_chain dut (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cin(cin),
    .dout_vld(dout_vld), .dout(dout), .cout(cout), .viol(viol),
    .viol_stage(viol_stage), .viol_cnt(viol_cnt)
  );

  sr_nv_ctf_chain #(.CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .din_vld(din_vld), .din(din), .cin(cin),
    .dout_vld(dout_vld_b), .dout(dout_b), .cout(cout_b), .viol(viol_b),
    .viol_stage(viol_stage_b), .viol_cnt(viol_cnt_b)
  );

  always #5 clk = ~clk;

  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  string scn   = "";

  int         cin_q[$], rst_q[$], din_t[$], dv_t[$], co_q[$], vi_t[$], vi_s[$];
  logic [3:0] din_v[$], dv_v[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s.%s cyc=%0d got=%0h exp=%0h", scn, tag, cyc, got, exp);
    end
  endtask

  function automatic logic has(input int q[$], input int t);
    foreach (q[k]) if (q[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clr();
    cin_q.delete(); rst_q.delete(); din_t.delete(); din_v.delete();
    dv_t.delete(); dv_v.delete(); co_q.delete(); vi_t.delete(); vi_s.delete();
  endtask

  // Reset (with cin/din_vld active in the last reset cycle), then play len cycles.
  task automatic run(input int len);
    logic       exp_dv, exp_vi;
    logic [3:0] exp_d;
    int         exp_vs, n;
    rst = 1'b1; cin = 1'b0; din_vld = 1'b0; din = '0;
    @(negedge clk);
    cin = 1'b1; din_vld = 1'b1; din = 4'hF;
    for (int t = 0; t < len; t++) begin
      @(negedge clk);
      cyc = t;
      exp_dv = 1'b0; exp_d = '0;
      foreach (dv_t[k]) if (dv_t[k] == t) begin exp_dv = 1'b1; exp_d = dv_v[k]; end
      exp_vi = 1'b0; exp_vs = 0; n = 0;
      foreach (vi_t[k]) begin
        if (vi_t[k] == t) begin exp_vi = 1'b1; exp_vs = vi_s[k]; end
        if (vi_t[k] <= t) n++;
      end
      chk("dout_vld", 32'(dout_vld), 32'(exp_dv));
      if (exp_dv) chk("dout", 32'(dout), 32'(exp_d));
      chk("cout", 32'(cout), 32'(has(co_q, t)));
      chk("viol", 32'(viol), 32'(exp_vi));
      chk("viol_b", 32'(viol_b), 32'(exp_vi));
`ifdef SR_NV_CTF_VIOL_CNT_EN
      if (exp_vi) chk("viol_stage", 32'(viol_stage), 32'(exp_vs));
      chk("viol_cnt", 32'(viol_cnt), 32'(n));
      chk("viol_cnt_sat", 32'(viol_cnt_b), 32'((n > 3) ? 3 : n));
`else
      chk("viol_stage", 32'(viol_stage), 32'(0));
      chk("viol_cnt", 32'(viol_cnt), 32'(0));
      chk("viol_cnt_sat", 32'(viol_cnt_b), 32'(0));
`endif
      rst     = has(rst_q, t);
      cin     = has(cin_q, t);
      din_vld = 1'b0;
      din     = '0;
      foreach (din_t[k]) if (din_t[k] == t) begin din_vld = 1'b1; din = din_v[k]; end
    end
  endtask

  initial begin
    // A travels to dout in four pulses; back-to-back pulse reads an empty stage.
    clr(); scn = "shift";
    din_t = '{0}; din_v = '{4'hA};
    cin_q = '{10, 30, 50, 70, 71};
    dv_t  = '{11, 31, 51, 71, 72}; dv_v = '{4'h0, 4'h0, 4'h0, 4'hA, 4'h0};
    co_q  = '{17, 37, 57, 77, 78};
    run(85);

    // Arrival one cycle before c0: setup violation, nothing propagates.
    clr(); scn = "setup";
    din_t = '{23}; din_v = '{4'h5};
    cin_q = '{18, 30, 40, 50, 60};
    dv_t  = '{19, 31, 41, 51, 61}; dv_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    co_q  = '{25, 37, 47, 57, 67};
    vi_t  = '{25}; vi_s = '{0};
    run(70);

    // Arrival one cycle after c0 is dropped; the next one is kept.
    clr(); scn = "hold";
    din_t = '{17, 18}; din_v = '{4'h3, 4'h3};
    cin_q = '{10, 30, 40, 50, 60};
    dv_t  = '{11, 31, 41, 51, 61}; dv_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h3};
    co_q  = '{17, 37, 47, 57, 67};
    vi_t  = '{18}; vi_s = '{0};
    run(70);

    // Clock and arrival in the same cycle: one setup violation, data discarded.
    clr(); scn = "simul";
    din_t = '{16}; din_v = '{4'hF};
    cin_q = '{10, 30, 40, 50, 60};
    dv_t  = '{11, 31, 41, 51, 61}; dv_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    co_q  = '{17, 37, 47, 57, 67};
    vi_t  = '{17}; vi_s = '{0};
    run(70);

    // Four back-to-back pulses plus five arrivals: five violations in a row.
    clr(); scn = "sat";
    din_t = '{16, 17, 18, 19, 20}; din_v = '{4'hF, 4'hF, 4'hF, 4'hF, 4'hF};
    cin_q = '{10, 11, 12, 13};
    dv_t  = '{11, 12, 13, 14}; dv_v = '{4'h0, 4'h0, 4'h0, 4'h0};
    co_q  = '{17, 18, 19, 20};
    vi_t  = '{17, 18, 19, 20, 21}; vi_s = '{0, 0, 0, 0, 0};
    run(30);

    // Reset drops the in-flight pulse and the loaded A.
    clr(); scn = "midrst";
    din_t = '{0}; din_v = '{4'hA};
    cin_q = '{10, 20, 30, 40, 50};
    rst_q = '{13};
    dv_t  = '{11, 21, 31, 41, 51}; dv_v = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
    co_q  = '{27, 37, 47, 57};
    run(60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
